// File: rtl/fifo_rd_ctrl_if.sv
// Downstream stream bundle for the FIFO read controller: registered valid/data
// toward the consumer, ready back from it.
interface fifo_rd_ctrl_if #(
    parameter type data_t = logic [7:0]
) ();
    logic  r_valid_o;
    logic  r_ready_i;
    data_t r_data_o;

    modport master (output r_valid_o, output r_data_o, input r_ready_i);
    modport slave  (input r_valid_o, input r_data_o, output r_ready_i);
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: read pointer, empty flag and a
// prefetching valid/ready output stage. FIFO_RD_LEVEL_EN adds the r_level_o fill count.
module fifo_rd_ctrl #(
    parameter type data_t     = logic [7:0],
    parameter int  ADDR_WIDTH = 8
) (
    input  logic                  clk_r_i,
    input  logic                  rst_r_i,
    input  logic [ADDR_WIDTH:0]   r_wptr_gray_i,
    output logic [ADDR_WIDTH-1:0] r_addr_o,
    input  data_t                 r_data_i,
    output logic [ADDR_WIDTH:0]   r_ptr_gray_o,
    output logic                  r_empty_o,
`ifdef FIFO_RD_LEVEL_EN
    output logic [ADDR_WIDTH+1:0] r_level_o,
`endif
    fifo_rd_ctrl_if.master        strm
);

    logic [ADDR_WIDTH:0] rbin_q, rbin_d;
    logic [ADDR_WIDTH:0] rgray_q, rgray_d;
    logic                empty_q, empty_d;
    logic                valid_q, valid_d;
    data_t               data_q, data_d;
    logic                fetch;

    always_comb begin
        fetch   = !empty_q && (!valid_q || strm.r_ready_i);
        rbin_d  = rbin_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (fetch) begin
            rbin_d  = rbin_q + 1'b1;
            valid_d = 1'b1;
            data_d  = r_data_i;
        end else if (valid_q && strm.r_ready_i) begin
            valid_d = 1'b0;
        end
        rgray_d = rbin_d ^ (rbin_d >> 1);
        // Full-width Gray compare so a wrapped write pointer never looks empty
        empty_d = (rgray_d == r_wptr_gray_i);
    end

    always_ff @(posedge clk_r_i) begin
        if (rst_r_i) begin
            rbin_q  <= '0;
            rgray_q <= '0;
            empty_q <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            empty_q <= empty_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign r_addr_o       = rbin_q[ADDR_WIDTH-1:0];
    assign r_ptr_gray_o   = rgray_q;
    assign r_empty_o      = empty_q;
    assign strm.r_valid_o = valid_q;
    assign strm.r_data_o  = data_q;

`ifdef FIFO_RD_LEVEL_EN
    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_WIDTH+1:0] level_q, level_d;
    logic [ADDR_WIDTH:0]   level_diff;

    // Words still in memory plus the one held in the output register
    always_comb begin
        level_diff = gray2bin(r_wptr_gray_i) - rbin_d;
        level_d    = {1'b0, level_diff} + {{(ADDR_WIDTH+1){1'b0}}, valid_d};
    end

    always_ff @(posedge clk_r_i) begin
        if (rst_r_i) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign r_level_o = level_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomized bench for fifo_rd_ctrl (ADDR_WIDTH=2) against a word-count/queue reference model.
module tb_fifo_rd_ctrl;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk_r_i = 1'b0;
    logic          rst_r_i;
    logic [AW:0]   r_wptr_gray_i;
    logic [AW-1:0] r_addr_o;
    logic [7:0]    r_data_i;
    logic [AW:0]   r_ptr_gray_o;
    logic          r_empty_o;
`ifdef FIFO_RD_LEVEL_EN
    logic [AW+1:0] r_level_o;
`endif

    fifo_rd_ctrl_if strm ();

    logic [7:0] mem [DEPTH];
    assign r_data_i = mem[r_addr_o];

    fifo_rd_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk_r_i       (clk_r_i),
        .rst_r_i       (rst_r_i),
        .r_wptr_gray_i (r_wptr_gray_i),
        .r_addr_o      (r_addr_o),
        .r_data_i      (r_data_i),
        .r_ptr_gray_o  (r_ptr_gray_o),
        .r_empty_o     (r_empty_o),
`ifdef FIFO_RD_LEVEL_EN
        .r_level_o     (r_level_o),
`endif
        .strm          (strm)
    );

    always #5 clk_r_i = ~clk_r_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: absolute word counts and a log of every word written
    logic [7:0] log_m [8192];
    int         wcount;
    int         rcount;
    bit         valid_m;
    bit         empty_m;
    logic [7:0] data_m;

    function automatic logic [AW:0] to_gray(int n);
        int b;
        b = n % (2 * DEPTH);
        return (AW+1)'(b ^ (b >> 1));
    endfunction

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_word();
        log_m[wcount]        = 8'($urandom);
        mem[wcount % DEPTH]  = log_m[wcount];
        wcount++;
        r_wptr_gray_i        = to_gray(wcount);
    endtask

    task automatic model_edge(bit rst, bit rdy);
        if (rst) begin
            rcount  = 0;
            valid_m = 1'b0;
            empty_m = 1'b1;
            data_m  = 8'h00;
        end else begin
            if (!empty_m && (!valid_m || rdy)) begin
                data_m  = log_m[rcount];
                valid_m = 1'b1;
                rcount++;
            end else if (valid_m && rdy) begin
                valid_m = 1'b0;
            end
            empty_m = (rcount == wcount);
        end
    endtask

    task automatic check_all(string tag);
        check_val({tag, ".empty"}, 32'(r_empty_o), 32'(empty_m));
        check_val({tag, ".valid"}, 32'(strm.r_valid_o), 32'(valid_m));
        check_val({tag, ".data"}, 32'(strm.r_data_o), 32'(data_m));
        check_val({tag, ".gray"}, 32'(r_ptr_gray_o), 32'(to_gray(rcount)));
        check_val({tag, ".addr"}, 32'(r_addr_o), 32'(rcount % DEPTH));
`ifdef FIFO_RD_LEVEL_EN
        check_val({tag, ".level"}, 32'(r_level_o), 32'(wcount - rcount + int'(valid_m)));
`endif
    endtask

    // One clock: apply inputs, advance DUT and model, compare away from the edge
    task automatic step(string tag, bit rst, bit rdy, int nwr);
        rst_r_i        = rst;
        strm.r_ready_i = rdy;
        for (int i = 0; i < nwr; i++) begin
            if (wcount - rcount < DEPTH) push_word();
        end
        @(posedge clk_r_i);
        model_edge(rst, rdy);
        @(negedge clk_r_i);
        check_all(tag);
    endtask

    // Whole-FIFO reset: the write side restarts with npre words already stored
    task automatic reset_seq(string tag, int npre, int ncyc);
        wcount        = 0;
        rcount        = 0;
        r_wptr_gray_i = '0;
        for (int i = 0; i < npre; i++) push_word();
        for (int i = 0; i < ncyc; i++) step(tag, 1'b1, 1'b0, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        rst_r_i        = 1'b1;
        strm.r_ready_i = 1'b0;
        r_wptr_gray_i  = '0;
        wcount         = 0;
        rcount         = 0;
        @(negedge clk_r_i);

        // Reset with write pointer at 2: empty stays set until one edge after release
        reset_seq("rst", 2, 2);
        step("rst_rel", 1'b0, 1'b0, 0);
        step("rst_rel", 1'b0, 1'b0, 0);

        // Four preloaded words streamed at full rate
        reset_seq("burst_rst", 4, 2);
        for (int i = 0; i < 6; i++) step("burst", 1'b0, 1'b1, 0);

        // Backpressure then release
        reset_seq("bp_rst", 4, 2);
        for (int i = 0; i < 6; i++) step("bp_hold", 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++) step("bp_rel", 1'b0, 1'b1, 0);

        // Continuous write/read across pointer wrap
        reset_seq("wrap_rst", 0, 2);
        for (int i = 0; i < 16; i++) step("wrap", 1'b0, 1'b1, 1);
        for (int i = 0; i < 4; i++) step("wrap_drain", 1'b0, 1'b1, 0);

        // Reset while a word is held and more are pending
        reset_seq("mid_rst0", 4, 1);
        for (int i = 0; i < 3; i++) step("mid_fill", 1'b0, 1'b0, 0);
        reset_seq("mid_rst", 0, 1);

        // Randomized traffic in blocks with different ready/write densities
        for (int blk = 0; blk < 60; blk++) begin
            int mode;
            mode = int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                reset_seq("rnd_rst", int'($urandom_range(0, DEPTH)), int'($urandom_range(1, 2)));
            end
            for (int c = 0; c < 40; c++) begin
                bit rdy;
                int nwr;
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = 1'b0;
                    default: rdy = 1'($urandom);
                endcase
                nwr = (mode == 3) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 1));
                step("rnd", 1'b0, rdy, nwr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
